// File: rtl/trace_packet_dma_pkg.sv
// Shared encodings for the trace packet DMA: NoC flit types and
// the packet-writer FSM states.
package trace_packet_dma_pkg;

  typedef enum logic [1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEAD    = 2'b01,
    FLIT_LAST    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_HEADER  = 3'd3,
    ST_PUSH    = 3'd4
  } dma_state_e;

  function automatic logic is_tail(input flit_type_e t);
    return (t == FLIT_LAST) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/trace_packet_dma_flit_packer.sv
// Packs 16-bit flits big-endian into bus words; tracks the flit count,
// the truncation flag and the index of the next data word in the slot.
module trace_flit_packer
  import trace_packet_dma_pkg::*;
#(
  parameter int unsigned NOC_DATA_WIDTH = 16,
  parameter int unsigned NOC_TYPE_WIDTH = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SLOT_SIZE      = 64,
  localparam int unsigned WIW = $clog2(SLOT_SIZE / 4)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      take_i,
  input  logic [NOC_TYPE_WIDTH-1:0] type_i,
  input  logic [NOC_DATA_WIDTH-1:0] data_i,
  input  logic                      wdone_i,
  output logic [DATA_WIDTH-1:0]     word_o,
  output logic [DATA_WIDTH-1:0]     header_o,
  output logic [WIW-1:0]            widx_o,
  output logic                      to_write_o,
  output logic                      to_header_o,
  output logic                      ended_o
);

  localparam int unsigned CAP = (SLOT_SIZE / 4 - 1) * 2;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [15:0]           cnt_q, cnt_d, cnt_inc;
  logic [WIW-1:0]        widx_q, widx_d;
  logic                  trunc_q, trunc_d;
  logic                  ended_q, ended_d;
  flit_type_e            ftype;
  logic                  tail, in_cap;

  assign ftype   = flit_type_e'(type_i);
  assign tail    = is_tail(ftype);
  assign in_cap  = cnt_q < 16'(CAP);
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // cap is even, so a truncated flit never leaves a half-filled word behind
  assign to_write_o  = take_i && in_cap && (cnt_q[0] || tail);
  assign to_header_o = take_i && !in_cap && tail;

  assign word_o   = word_q;
  assign widx_o   = widx_q;
  assign ended_o  = ended_q;
  assign header_o = DATA_WIDTH'({cnt_q, trunc_q, 15'h0});

  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    trunc_d = trunc_q;
    ended_d = ended_q;
    if (start_i) begin
      word_d  = DATA_WIDTH'({data_i, {NOC_DATA_WIDTH{1'b0}}});
      cnt_d   = 16'd1;
      widx_d  = '0;
      trunc_d = 1'b0;
      ended_d = (ftype == FLIT_SINGLE);
    end else if (take_i) begin
      cnt_d   = cnt_inc;
      ended_d = tail;
      if (!in_cap) begin
        trunc_d = 1'b1;
      end else if (cnt_q[0]) begin
        word_d[NOC_DATA_WIDTH-1:0] = data_i;
      end else begin
        word_d = DATA_WIDTH'({data_i, {NOC_DATA_WIDTH{1'b0}}});
      end
    end
    if (wdone_i) begin
      widx_d = widx_q + WIW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      trunc_q <= 1'b0;
      ended_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      trunc_q <= trunc_d;
      ended_q <= ended_d;
    end
  end

endmodule

// File: rtl/trace_packet_dma.sv
// Writes NoC trace packets into a ring of memory slots over Wishbone,
// then hands each filled slot's base address to the ready queue.
module trace_packet_dma
  import trace_packet_dma_pkg::*;
#(
  parameter int unsigned NOC_DATA_WIDTH = 16,
  parameter int unsigned NOC_TYPE_WIDTH = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BUFFER_BASE = 32'h0010_0000,
  parameter int unsigned SLOT_SIZE      = 64,
  parameter int unsigned NUM_SLOTS      = 16,
  localparam int unsigned NOC_FLIT_WIDTH = NOC_TYPE_WIDTH + NOC_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NOC_FLIT_WIDTH-1:0] noc_in_flit,
  input  logic                      noc_in_valid,
  output logic                      noc_in_ready,
  output logic [ADDRESS_WIDTH-1:0]  wbm_adr_o,
  output logic [DATA_WIDTH-1:0]     wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0]   wbm_sel_o,
  output logic                      wbm_we_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i,
  output logic                      fifo_store_packet,
  output logic [ADDRESS_WIDTH-1:0]  bus_initial_trace_address,
  input  logic                      address_ack,
  input  logic                      slot_release
);

  localparam int unsigned SW   = $clog2(NUM_SLOTS);
  localparam int unsigned OW   = SW + 1;
  localparam int unsigned SLOG = $clog2(SLOT_SIZE);
  localparam int unsigned WIW  = $clog2(SLOT_SIZE / 4);

  dma_state_e            state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [OW-1:0]         occ_q, occ_d;
  flit_type_e            ftype;
  logic                  acc, start, take, bus_done, wdone, rel_ok;
  logic [ADDRESS_WIDTH-1:0] slot_base;
  logic [DATA_WIDTH-1:0] word, header;
  logic [WIW-1:0]        widx;
  logic                  to_write, to_header, ended;

  assign ftype    = flit_type_e'(noc_in_flit[NOC_FLIT_WIDTH-1:NOC_DATA_WIDTH]);
  assign acc      = noc_in_valid && noc_in_ready;
  assign start    = acc && (state_q == ST_IDLE) &&
                    ((ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE));
  assign take     = acc && (state_q == ST_COLLECT);
  assign bus_done = wbm_ack_i || wbm_err_i;
  assign wdone    = (state_q == ST_WRITE) && bus_done;
  assign rel_ok   = slot_release && (occ_q != '0);

  assign slot_base = BUFFER_BASE + (ADDRESS_WIDTH'(slot_q) << SLOG);

  trace_flit_packer #(
    .NOC_DATA_WIDTH (NOC_DATA_WIDTH),
    .NOC_TYPE_WIDTH (NOC_TYPE_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .SLOT_SIZE      (SLOT_SIZE)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .take_i      (take),
    .type_i      (noc_in_flit[NOC_FLIT_WIDTH-1:NOC_DATA_WIDTH]),
    .data_i      (noc_in_flit[NOC_DATA_WIDTH-1:0]),
    .wdone_i     (wdone),
    .word_o      (word),
    .header_o    (header),
    .widx_o      (widx),
    .to_write_o  (to_write),
    .to_header_o (to_header),
    .ended_o     (ended)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    occ_d   = occ_q;
    if (start && !rel_ok) begin
      occ_d = occ_q + OW'(1);
    end else if (rel_ok && !start) begin
      occ_d = occ_q - OW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (ftype == FLIT_SINGLE) ? ST_WRITE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (to_write) begin
          state_d = ST_WRITE;
        end else if (to_header) begin
          state_d = ST_HEADER;
        end
      end
      ST_WRITE: begin
        if (bus_done) begin
          state_d = ended ? ST_HEADER : ST_COLLECT;
        end
      end
      ST_HEADER: begin
        if (bus_done) begin
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (address_ack) begin
          state_d = ST_IDLE;
          slot_d  = slot_q + SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wbm_sel_o = '1;
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = wbm_cyc_o;

  always_comb begin
    noc_in_ready              = 1'b0;
    wbm_cyc_o                 = 1'b0;
    wbm_adr_o                 = '0;
    wbm_dat_o                 = '0;
    fifo_store_packet         = 1'b0;
    bus_initial_trace_address = '0;
    unique case (state_q)
      ST_IDLE: begin
        noc_in_ready = !rst && (occ_q < OW'(NUM_SLOTS));
      end
      ST_COLLECT: begin
        noc_in_ready = !rst;
      end
      ST_WRITE: begin
        wbm_cyc_o = 1'b1;
        wbm_adr_o = slot_base + ADDRESS_WIDTH'(4) +
                    (ADDRESS_WIDTH'(widx) << 2);
        wbm_dat_o = word;
      end
      ST_HEADER: begin
        wbm_cyc_o = 1'b1;
        wbm_adr_o = slot_base;
        wbm_dat_o = header;
      end
      ST_PUSH: begin
        fifo_store_packet         = 1'b1;
        bus_initial_trace_address = slot_base;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trace_packet_dma.sv
// Directed bench for trace_packet_dma: packet-level model of expected
// bus writes and slot pushes, plus literal checks on observed traffic.
module tb_trace_packet_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] noc_in_flit;
  logic        noc_in_valid;
  logic        noc_in_ready;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        fifo_store_packet;
  logic [31:0] bus_initial_trace_address;
  logic        address_ack = 1'b0;
  logic        slot_release;

  always #5 clk = ~clk;

  trace_packet_dma dut (
    .clk                       (clk),
    .rst                       (rst),
    .noc_in_flit               (noc_in_flit),
    .noc_in_valid              (noc_in_valid),
    .noc_in_ready              (noc_in_ready),
    .wbm_adr_o                 (wbm_adr_o),
    .wbm_dat_o                 (wbm_dat_o),
    .wbm_sel_o                 (wbm_sel_o),
    .wbm_we_o                  (wbm_we_o),
    .wbm_cyc_o                 (wbm_cyc_o),
    .wbm_stb_o                 (wbm_stb_o),
    .wbm_ack_i                 (wbm_ack_i),
    .wbm_err_i                 (wbm_err_i),
    .fifo_store_packet         (fifo_store_packet),
    .bus_initial_trace_address (bus_initial_trace_address),
    .address_ack               (address_ack),
    .slot_release              (slot_release)
  );

  typedef struct {
    bit          push;
    logic [31:0] adr;
    logic [31:0] dat;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  total = 0;
  int  bad = 0;
  int  model_slot = 0;
  bit  ack_en = 1'b1;
  bit  use_err = 1'b0;
  int  aack_delay = 0;
  int  push_wait = 0;
  int  last_wait = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input bit p, input logic [31:0] a,
                             input logic [31:0] d);
    ev_t e;
    e.push = p;
    e.adr  = a;
    e.dat  = d;
    return e;
  endfunction

  function automatic logic [31:0] oa(input int i);
    return (i < obs_q.size()) ? obs_q[i].adr : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] od(input int i);
    return (i < obs_q.size()) ? obs_q[i].dat : 32'hDEAD_BEEF;
  endfunction

  task automatic compare_event(input ev_t e);
    ev_t x;
    obs_q.push_back(e);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got push=%0d adr=%h dat=%h",
               e.push, e.adr, e.dat);
    end else begin
      x = exp_q.pop_front();
      check("ev_kind", 64'(e.push), 64'(x.push));
      check("ev_adr", 64'(e.adr), 64'(x.adr));
      if (!x.push) check("ev_dat", 64'(e.dat), 64'(x.dat));
    end
  endtask

  // bus responder and per-cycle compare against the model queue
  always @(negedge clk) begin : mon
    wbm_ack_i = wbm_cyc_o && ack_en && !use_err;
    wbm_err_i = wbm_cyc_o && ack_en && use_err;
    push_wait = fifo_store_packet ? push_wait + 1 : 0;
    address_ack = fifo_store_packet && (push_wait > aack_delay);
    if (!rst) begin
      if (wbm_cyc_o || fifo_store_packet)
        check("ready_busy", 64'(noc_in_ready), 64'(0));
      if (wbm_cyc_o && (wbm_ack_i || wbm_err_i))
        compare_event(mk(1'b0, wbm_adr_o, wbm_dat_o));
      if (fifo_store_packet && exp_q.size() > 0) begin
        check("push_kind", 64'(exp_q[0].push), 64'(1));
        check("push_addr_stable", 64'(bus_initial_trace_address),
              64'(exp_q[0].adr));
      end
      if (fifo_store_packet && address_ack) begin
        last_wait = push_wait;
        compare_event(mk(1'b1, bus_initial_trace_address, 32'h0));
      end
    end
  end

  // packet-level model: data words, header, then the slot push
  task automatic model_pkt(input int n, input logic [15:0] d[$]);
    logic [31:0] b;
    logic [15:0] lo;
    logic [15:0] cnt;
    int w;
    b = 32'h0010_0000 + 32'(model_slot * 64);
    w = (n < 30) ? n : 30;
    for (int i = 0; i < w; i += 2) begin
      lo = (i + 1 < w) ? d[i+1] : 16'h0;
      exp_q.push_back(mk(1'b0, b + 32'(4 + 2 * i), {d[i], lo}));
    end
    cnt = (n > 65535) ? 16'hFFFF : 16'(n);
    exp_q.push_back(mk(1'b0, b, {cnt, (n > 30), 15'h0}));
    exp_q.push_back(mk(1'b1, b, 32'h0));
    model_slot = (model_slot + 1) % 16;
  endtask

  task automatic send_flit(input logic [1:0] t, input logic [15:0] d);
    int k;
    noc_in_flit  = {t, d};
    noc_in_valid = 1'b1;
    k = 0;
    while (!noc_in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      total++;
      bad++;
      $display("FAIL flit_timeout: got ready=0 required ready=1");
    end else begin
      @(negedge clk);
    end
    noc_in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [15:0] d[$]);
    logic [1:0] t;
    model_pkt(n, d);
    for (int i = 0; i < n; i++) begin
      if (n == 1) t = 2'b11;
      else if (i == 0) t = 2'b01;
      else if (i == n - 1) t = 2'b10;
      else t = 2'b00;
      send_flit(t, d[i]);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    model_slot = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] q[$];
    int k;
    rst = 1'b1;
    noc_in_valid = 1'b0;
    noc_in_flit = '0;
    slot_release = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", 64'(wbm_cyc_o), 64'(0));
    check("rst_stb", 64'(wbm_stb_o), 64'(0));
    check("rst_we", 64'(wbm_we_o), 64'(0));
    check("rst_sel", 64'(wbm_sel_o), 64'(4'hF));
    check("rst_adr", 64'(wbm_adr_o), 64'(0));
    check("rst_dat", 64'(wbm_dat_o), 64'(0));
    check("rst_fifo", 64'(fifo_store_packet), 64'(0));
    check("rst_bia", 64'(bus_initial_trace_address), 64'(0));
    check("rst_ready", 64'(noc_in_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(noc_in_ready), 64'(1));
    slot_release = 1'b1;
    @(negedge clk);
    slot_release = 1'b0;

    // three-flit packet
    obs_q.delete();
    send_pkt(3, '{16'h1111, 16'h2222, 16'h3333});
    drain();
    check("p3_w0_adr", 64'(oa(0)), 64'(32'h0010_0004));
    check("p3_w0_dat", 64'(od(0)), 64'(32'h1111_2222));
    check("p3_w1_adr", 64'(oa(1)), 64'(32'h0010_0008));
    check("p3_w1_dat", 64'(od(1)), 64'(32'h3333_0000));
    check("p3_hdr_adr", 64'(oa(2)), 64'(32'h0010_0000));
    check("p3_hdr_dat", 64'(od(2)), 64'(32'h0003_0000));
    check("p3_push", 64'(oa(3)), 64'(32'h0010_0000));

    // single-flit packet, stray payload in IDLE, next slot
    do_reset();
    send_pkt(1, '{16'hABCD});
    send_flit(2'b00, 16'h9999);
    send_pkt(2, '{16'h5555, 16'h6666});
    drain();
    check("s_w0_adr", 64'(oa(0)), 64'(32'h0010_0004));
    check("s_w0_dat", 64'(od(0)), 64'(32'hABCD_0000));
    check("s_hdr_dat", 64'(od(1)), 64'(32'h0001_0000));
    check("s_push", 64'(oa(2)), 64'(32'h0010_0000));
    check("n_w0_adr", 64'(oa(3)), 64'(32'h0010_0044));
    check("n_w0_dat", 64'(od(3)), 64'(32'h5555_6666));
    check("n_hdr_dat", 64'(od(4)), 64'(32'h0002_0000));

    // 32-flit packet overflows the slot
    obs_q.delete();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(16'h0100 + 16'(i));
    send_pkt(32, q);
    drain();
    check("big_w14_adr", 64'(oa(14)), 64'(32'h0010_00BC));
    check("big_w14_dat", 64'(od(14)), 64'(32'h011C_011D));
    check("big_hdr_adr", 64'(oa(15)), 64'(32'h0010_0080));
    check("big_hdr_dat", 64'(od(15)), 64'(32'h0020_8000));
    check("big_events", 64'(obs_q.size()), 64'(17));

    // bus error terminates cycles like ack
    use_err = 1'b1;
    send_pkt(3, '{16'hC0DE, 16'hBEEF, 16'h0042});
    drain();
    use_err = 1'b0;

    // slow ready queue
    aack_delay = 10;
    send_pkt(1, '{16'h7E57});
    drain();
    check("aack_wait", 64'(last_wait), 64'(11));
    aack_delay = 0;

    // fill the ring, then free one slot
    do_reset();
    slot_release = 1'b1;
    @(negedge clk);
    slot_release = 1'b0;
    for (int p = 0; p < 16; p++) send_pkt(1, '{16'(16'h0A00 + p)});
    drain();
    obs_q.delete();
    noc_in_flit = {2'b01, 16'h7777};
    noc_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_ready", 64'(noc_in_ready), 64'(0));
    end
    slot_release = 1'b1;
    @(negedge clk);
    slot_release = 1'b0;
    send_pkt(2, '{16'h7777, 16'h8888});
    drain();
    check("wrap_w0_adr", 64'(oa(0)), 64'(32'h0010_0004));
    check("wrap_w0_dat", 64'(od(0)), 64'(32'h7777_8888));
    check("wrap_push", 64'(oa(2)), 64'(32'h0010_0000));

    // reset while a write is stalled
    do_reset();
    ack_en = 1'b0;
    send_flit(2'b11, 16'h4242);
    k = 0;
    while (!wbm_cyc_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cyc_before_rst", 64'(wbm_cyc_o), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("cyc_after_rst", 64'(wbm_cyc_o), 64'(0));
    check("fifo_after_rst", 64'(fifo_store_packet), 64'(0));
    rst = 1'b0;
    ack_en = 1'b1;
    exp_q.delete();
    obs_q.delete();
    model_slot = 0;
    @(negedge clk);
    send_pkt(1, '{16'h5A5A});
    drain();
    check("post_rst_adr", 64'(oa(0)), 64'(32'h0010_0004));
    check("post_rst_dat", 64'(od(0)), 64'(32'h5A5A_0000));
    check("post_rst_push", 64'(oa(2)), 64'(32'h0010_0000));

    check("final_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
